// File: rtl/sweep_stim_gen.sv
// Exhaustive 3-operand stimulus sweeper with a 16-bit MISR that compacts
// the downstream datapath response into a single signature.
module sweep_stim_gen #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           ready,
    input  logic [W-1:0]   out1,
    output logic [W-1:0]   in1,
    output logic [W-1:0]   in2,
    output logic [W-1:0]   in3,
    output logic           vec_valid,
    output logic           busy,
    output logic           done,
    output logic [3*W:0]   vec_count,
    output logic [15:0]    sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic           xfer;
    logic           last_vec;
    logic           sweep_begin;
    logic [3*W-1:0] vec_next;
    logic [15:0]    sig_next;

    assign xfer        = (state == RUN) && ready;
    assign last_vec    = &{in1, in2, in3};
    assign sweep_begin = (state != RUN) && start;

    // Treating the three operands as one counter gives in3-fastest order
    // with carries, and the final vector wraps back to all zeros.
    assign vec_next = {in1, in2, in3} + {{(3*W-1){1'b0}}, 1'b1};

    assign sig_next = {sig[14:0], 1'b0}
                    ^ (sig[15] ? 16'h1021 : 16'h0000)
                    ^ {{(16-W){1'b0}}, out1};

    // Status outputs decode the state flop directly, so they stay registered.
    assign vec_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (xfer && last_vec) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response is folded in on the same edge the vector is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n || sweep_begin) begin
            in1       <= '0;
            in2       <= '0;
            in3       <= '0;
            vec_count <= '0;
            sig       <= 16'h0000;
        end else if (xfer) begin
            {in1, in2, in3} <= vec_next;
            vec_count       <= vec_count + {{(3*W){1'b0}}, 1'b1};
            sig             <= sig_next;
        end
    end

endmodule
